// File: rtl/npu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// npu_seq_ctrl
// Run sequencer for the NPU datapath. A START rising edge launches one run:
// input-buffer load, MAC clear, a programmable number of MAC enable cycles,
// capture of N_CH accumulators with per-channel ReLU, then byte-wise
// serialisation of the captured results into the output FIFO under FIFO_FULL
// back-pressure. ABORT cancels a run from any busy state.
//
// Ports
//   CLKEXT          in   clock, rising edge
//   RST_GLO_N       in   asynchronous active-low reset
//   START           in   run request (rising edge accepted only when idle)
//   ABORT           in   cancel the current run
//   CFG_MAC_CYCLES  in   MAC enable cycles per run (0 behaves as 1)
//   CFG_RELU_BYP    in   per-channel ReLU bypass
//   ACC_IN          in   packed signed accumulators, channel i at [i*ACC_W +: ACC_W]
//   FIFO_FULL       in   output FIFO full
//   EN_BUF_IN       out  input buffer capture strobe
//   RST_MAC         out  MAC accumulator clear strobe
//   EN_MAC          out  MAC accumulate enable
//   FIFO_WR_EN      out  FIFO write strobe (combinational on FIFO_FULL)
//   FIFO_DIN        out  FIFO write data, current byte while writing, else 0
//   BUSY            out  run in progress
//   DONE            out  one-cycle pulse when a run completes
//   ABORTED         out  one-cycle pulse when a run is cancelled
// -----------------------------------------------------------------------------
module npu_seq_ctrl #(
  parameter int N_CH  = 2,
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input  logic                  CLKEXT,
  input  logic                  RST_GLO_N,
  input  logic                  START,
  input  logic                  ABORT,
  input  logic [CNT_W-1:0]      CFG_MAC_CYCLES,
  input  logic [N_CH-1:0]       CFG_RELU_BYP,
  input  logic [N_CH*ACC_W-1:0] ACC_IN,
  input  logic                  FIFO_FULL,
  output logic                  EN_BUF_IN,
  output logic                  RST_MAC,
  output logic                  EN_MAC,
  output logic                  FIFO_WR_EN,
  output logic [7:0]            FIFO_DIN,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ABORTED
);

  localparam int BPC   = ACC_W / 8;
  localparam int TOT_W = N_CH * ACC_W;
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int SUB_W = (BPC > 1) ? $clog2(BPC) : 1;
  localparam int OFF_W = $clog2(TOT_W);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    CLEAR   = 3'd2,
    COMPUTE = 3'd3,
    CAPTURE = 3'd4,
    WRITE   = 3'd5,
    FINISH  = 3'd6
  } state_t;

  state_t             state;
  logic               start_q;
  logic [CNT_W-1:0]   mac_cycles;
  logic [CNT_W-1:0]   mac_cnt;
  logic [N_CH-1:0]    relu_byp;
  logic [TOT_W-1:0]   shadow;
  logic [CH_W-1:0]    ch_idx;
  logic [SUB_W-1:0]   sub_idx;
  logic               start_edge;
  logic               last_byte;
  logic               wr_issue;
  logic [OFF_W-1:0]   byte_off;

  assign start_edge = START & ~start_q;
  assign last_byte  = (ch_idx == CH_W'(N_CH - 1)) && (sub_idx == SUB_W'(BPC - 1));
  assign wr_issue   = (state == WRITE) && !FIFO_FULL;
  assign FIFO_WR_EN = wr_issue;

  // Bit offset of the current byte: channel 0 first, MSB byte first in a channel.
  always_comb begin
    byte_off = OFF_W'(int'(ch_idx) * ACC_W + (BPC - 1 - int'(sub_idx)) * 8);
  end

  // FIFO data presents the pending byte for the whole WRITE state, so it holds
  // steady across FIFO_FULL stalls.
  always_comb begin
    if (state == WRITE) begin
      FIFO_DIN = shadow[byte_off +: 8];
    end else begin
      FIFO_DIN = 8'd0;
    end
  end

  // Sequencer FSM; strobes are registered to match the state they belong to.
  always_ff @(posedge CLKEXT or negedge RST_GLO_N) begin
    if (!RST_GLO_N) begin
      state      <= IDLE;
      start_q    <= 1'b0;
      mac_cycles <= {CNT_W{1'b0}};
      mac_cnt    <= {CNT_W{1'b0}};
      relu_byp   <= {N_CH{1'b0}};
      shadow     <= {TOT_W{1'b0}};
      ch_idx     <= {CH_W{1'b0}};
      sub_idx    <= {SUB_W{1'b0}};
      EN_BUF_IN  <= 1'b0;
      RST_MAC    <= 1'b0;
      EN_MAC     <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      ABORTED    <= 1'b0;
    end else begin
      start_q   <= START;
      EN_BUF_IN <= 1'b0;
      RST_MAC   <= 1'b0;
      EN_MAC    <= 1'b0;
      DONE      <= 1'b0;
      ABORTED   <= 1'b0;
      if ((state != IDLE) && ABORT) begin
        // A byte issued in this same cycle still goes out via FIFO_WR_EN.
        state   <= IDLE;
        BUSY    <= 1'b0;
        ABORTED <= 1'b1;
        mac_cnt <= {CNT_W{1'b0}};
        ch_idx  <= {CH_W{1'b0}};
        sub_idx <= {SUB_W{1'b0}};
      end else begin
        case (state)
          IDLE: begin
            if (start_edge && !ABORT) begin
              state      <= LOAD;
              BUSY       <= 1'b1;
              EN_BUF_IN  <= 1'b1;
              mac_cycles <= (CFG_MAC_CYCLES == {CNT_W{1'b0}}) ? CNT_W'(1) : CFG_MAC_CYCLES;
              relu_byp   <= CFG_RELU_BYP;
            end else begin
              state <= IDLE;
            end
          end
          LOAD: begin
            state   <= CLEAR;
            RST_MAC <= 1'b1;
          end
          CLEAR: begin
            state   <= COMPUTE;
            EN_MAC  <= 1'b1;
            mac_cnt <= {CNT_W{1'b0}};
          end
          COMPUTE: begin
            if (mac_cnt == (mac_cycles - CNT_W'(1))) begin
              state   <= CAPTURE;
              mac_cnt <= {CNT_W{1'b0}};
            end else begin
              mac_cnt <= mac_cnt + CNT_W'(1);
              EN_MAC  <= 1'b1;
            end
          end
          CAPTURE: begin
            // ReLU: a negative accumulator is clamped to zero unless bypassed.
            for (int i = 0; i < N_CH; i++) begin
              if (!relu_byp[i] && ACC_IN[i*ACC_W + ACC_W - 1]) begin
                shadow[i*ACC_W +: ACC_W] <= {ACC_W{1'b0}};
              end else begin
                shadow[i*ACC_W +: ACC_W] <= ACC_IN[i*ACC_W +: ACC_W];
              end
            end
            ch_idx  <= {CH_W{1'b0}};
            sub_idx <= {SUB_W{1'b0}};
            state   <= WRITE;
          end
          WRITE: begin
            if (wr_issue) begin
              if (last_byte) begin
                state <= FINISH;
                DONE  <= 1'b1;
              end else if (sub_idx == SUB_W'(BPC - 1)) begin
                sub_idx <= {SUB_W{1'b0}};
                ch_idx  <= ch_idx + CH_W'(1);
              end else begin
                sub_idx <= sub_idx + SUB_W'(1);
              end
            end else begin
              state <= WRITE;
            end
          end
          FINISH: begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_npu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_npu_seq_ctrl
// Self-checking bench for npu_seq_ctrl (N_CH=2, ACC_W=16, CNT_W=8). Stimulus is
// laid out per cycle in arrays, driven on the falling edge, and the outputs are
// sampled 1 ns later. A timeline reference model derives the expected outputs
// of every cycle from the run rules (offsets from the load cycle, byte list,
// stall cycles), and directed scenarios add fixed expected values.
// Trace word: [14]BUSY [13]DONE [12]ABORTED [11]EN_BUF_IN [10]RST_MAC
//             [9]EN_MAC [8]FIFO_WR_EN [7:0]FIFO_DIN
// -----------------------------------------------------------------------------
module tb_npu_seq_ctrl;

  localparam int N_CH  = 2;
  localparam int ACC_W = 16;
  localparam int CNT_W = 8;
  localparam int BPC   = ACC_W / 8;
  localparam int NB    = N_CH * BPC;
  localparam int MAXC  = 256;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic                  start = 1'b0;
  logic                  abort = 1'b0;
  logic [CNT_W-1:0]      cfg_mac = 8'd0;
  logic [N_CH-1:0]       cfg_byp = 2'd0;
  logic [N_CH*ACC_W-1:0] acc_in = 32'd0;
  logic                  fifo_full = 1'b0;
  logic                  en_buf_in, rst_mac, en_mac, fifo_wr_en, busy, done, aborted;
  logic [7:0]            fifo_din;

  int n_cmp = 0;
  int n_err = 0;

  logic                  st_start [MAXC];
  logic                  st_abort [MAXC];
  logic                  st_full  [MAXC];
  logic [CNT_W-1:0]      st_mac   [MAXC];
  logic [N_CH-1:0]       st_byp   [MAXC];
  logic [N_CH*ACC_W-1:0] st_acc   [MAXC];
  logic [14:0]           obs      [MAXC];
  logic [14:0]           expw     [MAXC];

  npu_seq_ctrl #(.N_CH(N_CH), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .CLKEXT         (clk),
    .RST_GLO_N      (rst_n),
    .START          (start),
    .ABORT          (abort),
    .CFG_MAC_CYCLES (cfg_mac),
    .CFG_RELU_BYP   (cfg_byp),
    .ACC_IN         (acc_in),
    .FIFO_FULL      (fifo_full),
    .EN_BUF_IN      (en_buf_in),
    .RST_MAC        (rst_mac),
    .EN_MAC         (en_mac),
    .FIFO_WR_EN     (fifo_wr_en),
    .FIFO_DIN       (fifo_din),
    .BUSY           (busy),
    .DONE           (done),
    .ABORTED        (aborted)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] out_word();
    return {busy, done, aborted, en_buf_in, rst_mac, en_mac, fifo_wr_en, fifo_din};
  endfunction

  // Expected byte k of a run: channel 0 first, MSB byte first, ReLU unless bypassed.
  function automatic logic [7:0] exp_byte(input logic [31:0] acc, input logic [1:0] byp, input int k);
    int ch;
    int sub;
    logic signed [15:0] v;
    ch  = k / BPC;
    sub = k % BPC;
    v   = acc[ch*16 +: 16];
    if (!byp[ch] && (v < 0)) v = 16'sd0;
    return v[(BPC-1-sub)*8 +: 8];
  endfunction

  task automatic clear_stim(input logic [7:0] m, input logic [1:0] b, input logic [31:0] a);
    for (int c = 0; c < MAXC; c++) begin
      st_start[c] = 1'b0;
      st_abort[c] = 1'b0;
      st_full[c]  = 1'b0;
      st_mac[c]   = m;
      st_byp[c]   = b;
      st_acc[c]   = a;
    end
  endtask

  // Drive n cycles of stimulus and record the outputs; then drain to idle.
  task automatic run_trace(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      start     = st_start[c];
      abort     = st_abort[c];
      fifo_full = st_full[c];
      cfg_mac   = st_mac[c];
      cfg_byp   = st_byp[c];
      acc_in    = st_acc[c];
      #1;
      obs[c] = out_word();
    end
    @(negedge clk);
    start = 1'b0;
    fifo_full = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Timeline model: each run is LOAD at t0, CLEAR at t0+1, M MAC cycles, one
  // capture cycle, then NB bytes issued on non-full cycles, then DONE.
  task automatic build_expected(input int n);
    bit run;
    bit prev;
    bit ab_next;
    int t0;
    int m;
    int wdone;
    int done_c;
    logic [1:0] byp;
    logic [7:0] bytes [NB];
    run = 1'b0; prev = 1'b0; ab_next = 1'b0;
    t0 = 0; m = 1; wdone = 0; done_c = -1; byp = 2'd0;
    for (int k = 0; k < NB; k++) bytes[k] = 8'd0;
    for (int c = 0; c < n; c++) begin
      logic [14:0] e;
      int p;
      e = 15'd0;
      if (ab_next) e[12] = 1'b1;
      ab_next = 1'b0;
      if (run) begin
        p = c - t0;
        e[14] = 1'b1;
        if (p == 0) e[11] = 1'b1;
        if (p == 1) e[10] = 1'b1;
        if (p >= 2 && p < 2 + m) e[9] = 1'b1;
        if (p == 2 + m) begin
          for (int k = 0; k < NB; k++) bytes[k] = exp_byte(st_acc[c], byp, k);
        end
        if (c == done_c) e[13] = 1'b1;
        if (p >= 3 + m && wdone < NB) begin
          e[7:0] = bytes[wdone];
          if (!st_full[c]) begin
            e[8] = 1'b1;
            wdone++;
            if (wdone == NB) done_c = c + 1;
          end
        end
        if (st_abort[c]) begin
          run = 1'b0;
          ab_next = 1'b1;
        end else if (c == done_c) begin
          run = 1'b0;
        end
      end else if (st_start[c] && !prev && !st_abort[c]) begin
        run = 1'b1;
        t0 = c + 1;
        m = (st_mac[c] == 8'd0) ? 1 : int'(st_mac[c]);
        byp = st_byp[c];
        wdone = 0;
        done_c = -1;
      end
      prev = st_start[c];
      expw[c] = e;
    end
  endtask

  // Summarise an observed trace (no checking here).
  task automatic scan(input int n, output int done_at, output int n_done, output int n_mac,
                      output int n_wr, output logic [31:0] bytes);
    done_at = -1; n_done = 0; n_mac = 0; n_wr = 0; bytes = 32'd0;
    for (int c = 0; c < n; c++) begin
      if (obs[c][13]) begin
        if (done_at < 0) done_at = c;
        n_done++;
      end
      if (obs[c][9]) n_mac++;
      if (obs[c][8]) begin
        n_wr++;
        bytes = {bytes[23:0], obs[c][7:0]};
      end
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_word() !== 15'd0) begin
      n_err++;
      $display("FAIL reset_async: got %h expected %h", out_word(), 15'd0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (out_word() !== 15'd0) begin
      n_err++;
      $display("FAIL reset_idle: got %h expected %h", out_word(), 15'd0);
    end
  endtask

  task automatic test_basic();
    int da, nd, nm, nw;
    logic [31:0] by;
    clear_stim(8'd4, 2'b00, 32'h0123FF10);
    st_start[0] = 1'b1;
    build_expected(20);
    run_trace(20);
    for (int c = 0; c < 20; c++) begin
      n_cmp++;
      if (obs[c] !== expw[c]) begin
        n_err++;
        $display("FAIL basic_trace cyc %0d: got %h expected %h", c, obs[c], expw[c]);
      end
    end
    scan(20, da, nd, nm, nw, by);
    n_cmp++;
    if (da !== 12 || nd !== 1) begin
      n_err++;
      $display("FAIL basic_done: got cycle %0d count %0d expected cycle 12 count 1", da, nd);
    end
    n_cmp++;
    if (nm !== 4) begin
      n_err++;
      $display("FAIL basic_en_mac: got %0d cycles expected 4", nm);
    end
    n_cmp++;
    if (nw !== 4 || by !== 32'h00000123) begin
      n_err++;
      $display("FAIL basic_bytes: got %0d bytes %h expected 4 bytes 00000123", nw, by);
    end
  endtask

  task automatic test_relu_bypass();
    int da, nd, nm, nw;
    logic [31:0] by;
    clear_stim(8'd4, 2'b01, 32'h0123FF10);
    st_start[0] = 1'b1;
    build_expected(20);
    run_trace(20);
    for (int c = 0; c < 20; c++) begin
      n_cmp++;
      if (obs[c] !== expw[c]) begin
        n_err++;
        $display("FAIL bypass_trace cyc %0d: got %h expected %h", c, obs[c], expw[c]);
      end
    end
    scan(20, da, nd, nm, nw, by);
    n_cmp++;
    if (nw !== 4 || by !== 32'hFF100123) begin
      n_err++;
      $display("FAIL bypass_bytes: got %0d bytes %h expected 4 bytes ff100123", nw, by);
    end
  endtask

  task automatic test_backpressure();
    int da, nd, nm, nw;
    logic [31:0] by;
    clear_stim(8'd4, 2'b00, 32'h0123FF10);
    st_start[0] = 1'b1;
    for (int c = 10; c <= 12; c++) st_full[c] = 1'b1;
    build_expected(24);
    run_trace(24);
    for (int c = 0; c < 24; c++) begin
      n_cmp++;
      if (obs[c] !== expw[c]) begin
        n_err++;
        $display("FAIL bp_trace cyc %0d: got %h expected %h", c, obs[c], expw[c]);
      end
    end
    for (int c = 10; c <= 12; c++) begin
      n_cmp++;
      if (obs[c][8:0] !== 9'h001) begin
        n_err++;
        $display("FAIL bp_stall cyc %0d: got wr/din %h expected 001", c, obs[c][8:0]);
      end
    end
    scan(24, da, nd, nm, nw, by);
    n_cmp++;
    if (da !== 15 || nw !== 4 || by !== 32'h00000123) begin
      n_err++;
      $display("FAIL bp_done: got cycle %0d bytes %0d %h expected cycle 15 bytes 4 00000123", da, nw, by);
    end
  endtask

  task automatic test_abort();
    int da, nd, nm, nw;
    logic [31:0] by;
    clear_stim(8'd4, 2'b00, 32'h0123FF10);
    st_start[0] = 1'b1;
    st_abort[4] = 1'b1;
    build_expected(20);
    run_trace(20);
    for (int c = 0; c < 20; c++) begin
      n_cmp++;
      if (obs[c] !== expw[c]) begin
        n_err++;
        $display("FAIL abort_trace cyc %0d: got %h expected %h", c, obs[c], expw[c]);
      end
    end
    scan(20, da, nd, nm, nw, by);
    n_cmp++;
    if (obs[5] !== 15'h1000 || nd !== 0 || nw !== 0) begin
      n_err++;
      $display("FAIL abort_mid: got cyc5 %h done %0d writes %0d expected 1000 0 0", obs[5], nd, nw);
    end
    // Abort coinciding with the last byte: byte still written, no DONE.
    clear_stim(8'd4, 2'b00, 32'h0123FF10);
    st_start[0] = 1'b1;
    st_abort[11] = 1'b1;
    build_expected(20);
    run_trace(20);
    for (int c = 0; c < 20; c++) begin
      n_cmp++;
      if (obs[c] !== expw[c]) begin
        n_err++;
        $display("FAIL abort_last_trace cyc %0d: got %h expected %h", c, obs[c], expw[c]);
      end
    end
    scan(20, da, nd, nm, nw, by);
    n_cmp++;
    if (nd !== 0 || nw !== 4 || by !== 32'h00000123 || obs[12][12] !== 1'b1) begin
      n_err++;
      $display("FAIL abort_last: got done %0d bytes %0d %h aborted %b expected 0 4 00000123 1",
               nd, nw, by, obs[12][12]);
    end
  endtask

  task automatic test_start_level();
    int da, nd, nm, nw;
    logic [31:0] by;
    clear_stim(8'd0, 2'b00, 32'h7FFF8001);
    for (int c = 0; c < 20; c++) st_start[c] = 1'b1;
    build_expected(30);
    run_trace(30);
    for (int c = 0; c < 30; c++) begin
      n_cmp++;
      if (obs[c] !== expw[c]) begin
        n_err++;
        $display("FAIL level_trace cyc %0d: got %h expected %h", c, obs[c], expw[c]);
      end
    end
    scan(30, da, nd, nm, nw, by);
    n_cmp++;
    if (nm !== 1 || nd !== 1 || da !== 9 || by !== 32'h00007FFF) begin
      n_err++;
      $display("FAIL level_run: got mac %0d done %0d at %0d bytes %h expected 1 1 9 00007fff",
               nm, nd, da, by);
    end
    clear_stim(8'd2, 2'b11, 32'h12345678);
    st_start[0] = 1'b1;
    st_start[3] = 1'b1;
    build_expected(20);
    run_trace(20);
    scan(20, da, nd, nm, nw, by);
    n_cmp++;
    if (nd !== 1 || nw !== 4 || da !== 10) begin
      n_err++;
      $display("FAIL busy_pulse: got done %0d at %0d writes %0d expected 1 at 10 writes 4", nd, da, nw);
    end
  endtask

  task automatic test_abort_idle();
    clear_stim(8'd3, 2'b00, 32'h0);
    st_start[0] = 1'b1;
    st_abort[0] = 1'b1;
    build_expected(12);
    run_trace(12);
    for (int c = 0; c < 12; c++) begin
      n_cmp++;
      if (obs[c] !== 15'd0) begin
        n_err++;
        $display("FAIL abort_idle cyc %0d: got %h expected 0000", c, obs[c]);
      end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      for (int c = 0; c < 200; c++) begin
        st_start[c] = (c < 160) && ($urandom_range(0, 4) == 0);
        st_abort[c] = (c < 160) && ($urandom_range(0, 39) == 0);
        st_full[c]  = ($urandom_range(0, 3) == 0);
        st_mac[c]   = 8'($urandom_range(0, 12));
        st_byp[c]   = 2'($urandom_range(0, 3));
        st_acc[c]   = $urandom;
      end
      build_expected(200);
      run_trace(200);
      for (int c = 0; c < 200; c++) begin
        n_cmp++;
        if (obs[c] !== expw[c]) begin
          n_err++;
          $display("FAIL random_trace t%0d cyc %0d: got %h expected %h", t, c, obs[c], expw[c]);
        end
      end
    end
  endtask

  task automatic test_reset_midrun();
    int da, nd, nm, nw;
    logic [31:0] by;
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    cfg_mac = 8'd3; cfg_byp = 2'b00; acc_in = 32'h11112222; start = 1'b1;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (fifo_wr_en) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL midrun_write: got no FIFO write within 40 cycles expected one");
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_word() !== 15'd0) begin
      n_err++;
      $display("FAIL midrun_reset: got %h expected 0000", out_word());
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_stim(8'd3, 2'b10, 32'h8001F00F);
    st_start[0] = 1'b1;
    build_expected(20);
    run_trace(20);
    scan(20, da, nd, nm, nw, by);
    n_cmp++;
    if (nd !== 1 || da !== 11 || by !== 32'h00008001) begin
      n_err++;
      $display("FAIL midrun_rerun: got done %0d at %0d bytes %h expected 1 at 11 00008001", nd, da, by);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_relu_bypass();
    test_backpressure();
    test_abort();
    test_start_level();
    test_abort_idle();
    test_random();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
